ide_bus_if: RTL and testbench

CPU-side bus adapter sitting directly upstream of the IDE register/sector-buffer block. It decodes synchronous CPU memory cycles into the IDE window and turns each hit into a single-clock select/read/write strobe with a 3-bit register address. It captures the IDE read data for the CPU and stretches the CPU cycle with wait states. It also produces the one-clock instruction-acquisition pulse used for auto-increment timing.

---
 rtl/ide_bus_if.sv | 178 +++++++++++++++++
 tb/tb_ide_bus_if.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ide_bus_if.sv
// ide_bus_if: CPU-side adapter in front of the IDE register/sector-buffer block.
//
// Decodes synchronous CPU memory cycles that fall in the 8-byte IDE window at
// IDE_BASE. Each hit becomes a single-clock select/read/write strobe with a
// 3-bit register address. The IDE read data is captured for the CPU, and the
// CPU cycle can be stretched with wait states. The block also generates a
// registered one-clock pulse at the start of every instruction fetch.
//
// Configuration macro: IDE_BUS_WAIT_EN
//   defined   - cpu_ready drops for the two clocks between strobe and capture.
//   undefined - cpu_ready is tied high. The CPU must hold cpu_memen_n low for
//               at least 4 clk per IDE access.
//
// Ports:
//   clk, resetn            system clock; asynchronous active-low reset
//   cpu_a, cpu_memen_n,    CPU address, memory-cycle and write enables,
//   cpu_we_n, cpu_iaq      and the instruction-fetch flag
//   cpu_d_i / cpu_d_o      CPU write data / captured read data
//   cpu_d_oe               cpu_d_o is selected onto the CPU read mux
//   cpu_ready              low inserts wait states
//   ide_sel, ide_rdn,      one-clock select and read/write strobes
//   ide_wrn, ide_ab        with the register address
//   ide_wdata / ide_rdata  write data to / registered read data from IDE
//   iaqas                  one-clock pulse at the start of each fetch
module ide_bus_if #(
  parameter logic [15:0] IDE_BASE = 16'hFF40
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [15:0] cpu_a,
  input  logic        cpu_memen_n,
  input  logic        cpu_we_n,
  input  logic        cpu_iaq,
  input  logic [15:0] cpu_d_i,
  output logic [15:0] cpu_d_o,
  output logic        cpu_d_oe,
  output logic        cpu_ready,
  output logic        ide_sel,
  output logic        ide_rdn,
  output logic        ide_wrn,
  output logic [2:0]  ide_ab,
  output logic [15:0] ide_wdata,
  input  logic [15:0] ide_rdata,
  output logic        iaqas
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StStrobe  = 3'd1;
  localparam logic [2:0] StWait    = 3'd2;
  localparam logic [2:0] StCapture = 3'd3;
  localparam logic [2:0] StHold    = 3'd4;

  logic [2:0]  state_q, state_d;
  logic        we_q, we_d;
  logic        sel_q, sel_d;
  logic        rdn_q, rdn_d;
  logic        wrn_q, wrn_d;
  logic [2:0]  ab_q, ab_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] dout_q, dout_d;
  logic        doe_q, doe_d;
  logic        memen_prev_q;
  logic        iaqas_q;
  logic        hit;

  assign hit = ~cpu_memen_n & (cpu_a[15:3] == IDE_BASE[15:3]);

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    ab_d    = ab_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;
    doe_d   = doe_q;
    // Strobes default inactive so they last exactly one clock.
    sel_d   = 1'b0;
    rdn_d   = 1'b1;
    wrn_d   = 1'b1;
    case (state_q)
      StIdle: begin
        if (hit) begin
          state_d = StStrobe;
          ab_d    = cpu_a[2:0];
          we_d    = ~cpu_we_n;
          sel_d   = 1'b1;
          if (!cpu_we_n) begin
            wdata_d = cpu_d_i;
            wrn_d   = 1'b0;
          end else begin
            rdn_d = 1'b0;
          end
        end
      end
      StStrobe: state_d = StWait;
      StWait: begin
        state_d = StCapture;
        if (!we_q) begin
          dout_d = ide_rdata;
          doe_d  = 1'b1;
        end
      end
      StCapture: state_d = StHold;
      StHold: begin
        // Re-arm only after MEMEN is seen high, so one cycle gives one strobe.
        if (cpu_memen_n) begin
          state_d = StIdle;
          doe_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      sel_q   <= 1'b0;
      rdn_q   <= 1'b1;
      wrn_q   <= 1'b1;
      ab_q    <= 3'd0;
      wdata_q <= 16'h0000;
      dout_q  <= 16'h0000;
      doe_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      rdn_q   <= rdn_d;
      wrn_q   <= wrn_d;
      ab_q    <= ab_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      doe_q   <= doe_d;
    end
  end

  // Fetch-start pulse: independent of the decode, fires for any address.
  // memen_prev_q resets high so a fetch straight out of reset still pulses.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      memen_prev_q <= 1'b1;
      iaqas_q      <= 1'b0;
    end else begin
      memen_prev_q <= cpu_memen_n;
      iaqas_q      <= ~cpu_memen_n & cpu_iaq & memen_prev_q;
    end
  end

`ifdef IDE_BUS_WAIT_EN
  logic ready_q;

  // Low from the strobe edge until the capture edge: two wait clocks.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready_q <= 1'b1;
    end else if (state_q == StIdle && hit) begin
      ready_q <= 1'b0;
    end else if (state_q == StWait) begin
      ready_q <= 1'b1;
    end
  end

  assign cpu_ready = ready_q;
`else
  assign cpu_ready = 1'b1;
`endif

  assign ide_sel   = sel_q;
  assign ide_rdn   = rdn_q;
  assign ide_wrn   = wrn_q;
  assign ide_ab    = ab_q;
  assign ide_wdata = wdata_q;
  assign cpu_d_o   = dout_q;
  assign cpu_d_oe  = doe_q;
  assign iaqas     = iaqas_q;

endmodule

// File: tb/tb_ide_bus_if.sv
// Directed bench for ide_bus_if: a vector table for a write, a read and a
// non-hit fetch, then hand-written sequences for a long MEMEN hold and a
// reset asserted during the strobe clock.
module tb_ide_bus_if;

`ifdef IDE_BUS_WAIT_EN
  localparam bit WaitEn = 1'b1;
`else
  localparam bit WaitEn = 1'b0;
`endif

  logic        clk;
  logic        resetn;
  logic [15:0] cpu_a;
  logic        cpu_memen_n;
  logic        cpu_we_n;
  logic        cpu_iaq;
  logic [15:0] cpu_d_i;
  logic [15:0] cpu_d_o;
  logic        cpu_d_oe;
  logic        cpu_ready;
  logic        ide_sel;
  logic        ide_rdn;
  logic        ide_wrn;
  logic [2:0]  ide_ab;
  logic [15:0] ide_wdata;
  logic [15:0] ide_rdata;
  logic        iaqas;

  int checks = 0;
  int errors = 0;

  ide_bus_if #(.IDE_BASE(16'hFF40)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .cpu_a      (cpu_a),
    .cpu_memen_n(cpu_memen_n),
    .cpu_we_n   (cpu_we_n),
    .cpu_iaq    (cpu_iaq),
    .cpu_d_i    (cpu_d_i),
    .cpu_d_o    (cpu_d_o),
    .cpu_d_oe   (cpu_d_oe),
    .cpu_ready  (cpu_ready),
    .ide_sel    (ide_sel),
    .ide_rdn    (ide_rdn),
    .ide_wrn    (ide_wrn),
    .ide_ab     (ide_ab),
    .ide_wdata  (ide_wdata),
    .ide_rdata  (ide_rdata),
    .iaqas      (iaqas)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        memen_n;
    logic        we_n;
    logic        iaq;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] rdata;
    logic        sel;
    logic        rdn;
    logic        wrn;
    logic [2:0]  ab;
    logic [15:0] wdata;
    logic [15:0] d_o;
    logic        oe;
    logic        rdy;
    logic        iaqas;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(input logic memen_n, input logic we_n, input logic iaq,
                              input logic [15:0] a, input logic [15:0] d,
                              input logic [15:0] rdata, input logic sel, input logic rdn,
                              input logic wrn, input logic [2:0] ab,
                              input logic [15:0] wdata, input logic [15:0] d_o,
                              input logic oe, input logic rdy, input logic iaqas_e);
    vec_t v;
    v.memen_n = memen_n; v.we_n = we_n; v.iaq = iaq; v.a = a; v.d = d; v.rdata = rdata;
    v.sel = sel; v.rdn = rdn; v.wrn = wrn; v.ab = ab; v.wdata = wdata; v.d_o = d_o;
    v.oe = oe; v.rdy = rdy; v.iaqas = iaqas_e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Ready is only stretched when the wait-state option is built in.
  function automatic logic exp_rdy(input logic r);
    return WaitEn ? r : 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic memen_n, input logic we_n, input logic iaq,
                       input logic [15:0] a, input logic [15:0] d, input logic [15:0] rdata);
    cpu_memen_n = memen_n;
    cpu_we_n    = we_n;
    cpu_iaq     = iaq;
    cpu_a       = a;
    cpu_d_i     = d;
    ide_rdata   = rdata;
  endtask

  int sel_cnt;

  initial begin
    // memen we iaq addr data rdata | sel rdn wrn ab wdata d_o oe rdy iaqas
    // Write 16'hA5EC to 16'hFF46.
    vecs[0]  = mk(0, 0, 0, 16'hFF46, 16'hA5EC, 16'h0000, 1, 1, 0, 3'd6, 16'hA5EC, 16'h0000, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 16'hFF46, 16'hA5EC, 16'h0000, 0, 1, 1, 3'd6, 16'hA5EC, 16'h0000, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 16'hFF46, 16'hA5EC, 16'h0000, 0, 1, 1, 3'd6, 16'hA5EC, 16'h0000, 0, 1, 0);
    vecs[3]  = mk(0, 0, 0, 16'hFF46, 16'hA5EC, 16'h0000, 0, 1, 1, 3'd6, 16'hA5EC, 16'h0000, 0, 1, 0);
    vecs[4]  = mk(1, 1, 0, 16'hFF46, 16'h0000, 16'h0000, 0, 1, 1, 3'd6, 16'hA5EC, 16'h0000, 0, 1, 0);
    // Read 16'hFF40; rdata 16'h1234 shows up the clock after the strobe.
    vecs[5]  = mk(0, 1, 0, 16'hFF40, 16'h0000, 16'h0000, 1, 0, 1, 3'd0, 16'hA5EC, 16'h0000, 0, 0, 0);
    vecs[6]  = mk(0, 1, 0, 16'hFF40, 16'h0000, 16'h0000, 0, 1, 1, 3'd0, 16'hA5EC, 16'h0000, 0, 0, 0);
    vecs[7]  = mk(0, 1, 0, 16'hFF40, 16'h0000, 16'h1234, 0, 1, 1, 3'd0, 16'hA5EC, 16'h1234, 1, 1, 0);
    vecs[8]  = mk(0, 1, 0, 16'hFF40, 16'h0000, 16'h0000, 0, 1, 1, 3'd0, 16'hA5EC, 16'h1234, 1, 1, 0);
    vecs[9]  = mk(1, 1, 0, 16'hFF40, 16'h0000, 16'h0000, 0, 1, 1, 3'd0, 16'hA5EC, 16'h1234, 0, 1, 0);
    // Non-hit instruction fetch at 16'h8300.
    vecs[10] = mk(0, 1, 1, 16'h8300, 16'h0000, 16'h0000, 0, 1, 1, 3'd0, 16'hA5EC, 16'h1234, 0, 1, 1);
    vecs[11] = mk(0, 1, 1, 16'h8300, 16'h0000, 16'h0000, 0, 1, 1, 3'd0, 16'hA5EC, 16'h1234, 0, 1, 0);
    vecs[12] = mk(1, 1, 0, 16'h8300, 16'h0000, 16'h0000, 0, 1, 1, 3'd0, 16'hA5EC, 16'h1234, 0, 1, 0);

    // Reset for 3 clocks.
    resetn = 1'b0;
    drive(1, 1, 0, 16'h0000, 16'h0000, 16'h0000);
    repeat (3) tick();
    chk("rst sel", {15'd0, ide_sel}, 16'd0);
    chk("rst rdn", {15'd0, ide_rdn}, 16'd1);
    chk("rst wrn", {15'd0, ide_wrn}, 16'd1);
    chk("rst ab", {13'd0, ide_ab}, 16'd0);
    chk("rst wdata", ide_wdata, 16'h0000);
    chk("rst d_o", cpu_d_o, 16'h0000);
    chk("rst oe", {15'd0, cpu_d_oe}, 16'd0);
    chk("rst ready", {15'd0, cpu_ready}, 16'd1);
    chk("rst iaqas", {15'd0, iaqas}, 16'd0);
    resetn = 1'b1;
    tick();

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].memen_n, vecs[i].we_n, vecs[i].iaq, vecs[i].a, vecs[i].d, vecs[i].rdata);
      tick();
      chk($sformatf("v%0d sel", i), {15'd0, ide_sel}, {15'd0, vecs[i].sel});
      chk($sformatf("v%0d rdn", i), {15'd0, ide_rdn}, {15'd0, vecs[i].rdn});
      chk($sformatf("v%0d wrn", i), {15'd0, ide_wrn}, {15'd0, vecs[i].wrn});
      chk($sformatf("v%0d ab", i), {13'd0, ide_ab}, {13'd0, vecs[i].ab});
      chk($sformatf("v%0d wdata", i), ide_wdata, vecs[i].wdata);
      chk($sformatf("v%0d d_o", i), cpu_d_o, vecs[i].d_o);
      chk($sformatf("v%0d oe", i), {15'd0, cpu_d_oe}, {15'd0, vecs[i].oe});
      chk($sformatf("v%0d ready", i), {15'd0, cpu_ready}, {15'd0, exp_rdy(vecs[i].rdy)});
      chk($sformatf("v%0d iaqas", i), {15'd0, iaqas}, {15'd0, vecs[i].iaqas});
    end

    // MEMEN held low for 10 clocks on a hit: exactly one strobe.
    drive(0, 1, 0, 16'hFF47, 16'h0000, 16'h5A5A);
    sel_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ide_sel) sel_cnt++;
    end
    chk("hold strobes", sel_cnt[15:0], 16'd1);
    chk("hold ab", {13'd0, ide_ab}, 16'd7);
    chk("hold d_o", cpu_d_o, 16'h5A5A);
    drive(1, 1, 0, 16'hFF47, 16'h0000, 16'h0000);
    tick();
    chk("hold release oe", {15'd0, cpu_d_oe}, 16'd0);
    chk("hold release sel", {15'd0, ide_sel}, 16'd0);
    // One clock of MEMEN high is enough to re-arm.
    drive(0, 0, 0, 16'hFF42, 16'hBEEF, 16'h0000);
    tick();
    chk("rearm sel", {15'd0, ide_sel}, 16'd1);
    chk("rearm wrn", {15'd0, ide_wrn}, 16'd0);
    chk("rearm ab", {13'd0, ide_ab}, 16'd2);
    chk("rearm wdata", ide_wdata, 16'hBEEF);
    repeat (3) tick();
    drive(1, 1, 0, 16'hFF42, 16'h0000, 16'h0000);
    tick();

    // Reset asserted in the middle of the strobe clock.
    drive(0, 0, 0, 16'hFF41, 16'h1111, 16'h0000);
    tick();
    chk("pre-rst sel", {15'd0, ide_sel}, 16'd1);
    #2 resetn = 1'b0;
    #1;
    chk("mid-rst sel", {15'd0, ide_sel}, 16'd0);
    chk("mid-rst wrn", {15'd0, ide_wrn}, 16'd1);
    chk("mid-rst ab", {13'd0, ide_ab}, 16'd0);
    chk("mid-rst wdata", ide_wdata, 16'h0000);
    chk("mid-rst d_o", cpu_d_o, 16'h0000);
    chk("mid-rst ready", {15'd0, cpu_ready}, 16'd1);
    drive(1, 1, 0, 16'h0000, 16'h0000, 16'h0000);
    tick();
    resetn = 1'b1;
    sel_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (ide_sel || !ide_wrn) sel_cnt++;
    end
    chk("post-rst no strobe", sel_cnt[15:0], 16'd0);
    chk("post-rst ready", {15'd0, cpu_ready}, 16'd1);
    // FSM must be idle: a fresh read hit strobes on the next clock.
    drive(0, 1, 0, 16'hFF43, 16'h0000, 16'h0000);
    tick();
    chk("post-rst hit sel", {15'd0, ide_sel}, 16'd1);
    chk("post-rst hit rdn", {15'd0, ide_rdn}, 16'd0);
    chk("post-rst hit ab", {13'd0, ide_ab}, 16'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
